// File: rtl/sram_mm2s_reader_if.sv
// Bundle of control, SRAM read-port and output-stream signals for the
// memory-to-stream reader. The slave modport is the reader's view; the master modport is the environment's view.
interface sram_mm2s_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic                  sram_csb;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_dout;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport slave (
    input  start, base_addr, length, sram_dout, m_tready,
    output busy, done, sram_csb, sram_addr, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output start, base_addr, length, sram_dout, m_tready,
    input  busy, done, sram_csb, sram_addr, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/sram_mm2s_reader.sv
// Drains a contiguous, address-wrapping block of SRAM words into a valid/ready
// stream through a small FIFO, issuing reads only when the FIFO can absorb them.
module sram_mm2s_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  sram_mm2s_reader_if.slave bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = OCC_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      issue_cnt_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  csb_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_b_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [OCC_W-1:0]      count_q;
  logic [OCC_W-1:0]      count_d;

  logic                  valid_s;
  logic                  push_s;
  logic                  pop_s;
  logic [SUM_W-1:0]      need_s;
  logic [SUM_W-1:0]      cap_s;
  logic                  room_s;

  assign valid_s = (count_q != OCC_W'(0));
  assign push_s  = rd_b_q;
  assign pop_s   = valid_s & bus.m_tready;
  assign count_d = count_q + OCC_W'(push_s) - OCC_W'(pop_s);

  // Worst-case occupancy once the current stage-A/B reads and one new read all land.
  assign need_s = SUM_W'(count_q) + SUM_W'(!csb_q) + SUM_W'(rd_b_q) + SUM_W'(1);
  assign cap_s  = SUM_W'(FIFO_DEPTH) + SUM_W'(pop_s);
  assign room_s = (need_s <= cap_s);

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sram_csb  = csb_q;
  assign bus.sram_addr = addr_q;
  assign bus.m_tvalid  = valid_s;
  assign bus.m_tdata   = fifo_mem_q[rd_ptr_q];
  assign bus.m_tlast   = valid_s & (beat_cnt_q == (len_q - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      csb_q       <= 1'b1;
      addr_q      <= '0;
      rd_b_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_b_q <= !csb_q;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          csb_q  <= 1'b1;
          if (bus.start) begin
            base_q      <= bus.base_addr;
            len_q       <= bus.length;
            beat_cnt_q  <= '0;
            if (bus.length == CNT_W'(0)) begin
              issue_cnt_q <= '0;
              state_q     <= DONE;
              done_q      <= 1'b1;
            end else begin
              issue_cnt_q <= CNT_W'(1);
              csb_q       <= 1'b0;
              addr_q      <= bus.base_addr;
              busy_q      <= 1'b1;
              state_q     <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (issue_cnt_q == len_q) begin
            csb_q   <= 1'b1;
            state_q <= DRAIN;
          end else if (room_s) begin
            csb_q       <= 1'b0;
            addr_q      <= base_q + issue_cnt_q[ADDR_WIDTH-1:0];
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          end else begin
            csb_q <= 1'b1;
          end
        end
        DRAIN: begin
          csb_q <= 1'b1;
          // Exit only when nothing is buffered and no read is still in flight.
          if ((count_d == OCC_W'(0)) && csb_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRAIN;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          csb_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          csb_q   <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
      if (pop_s) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // Output FIFO: stage-B SRAM data is written at the end of the cycle it is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= bus.sram_dout;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_sram_mm2s_reader.sv
// Bench for sram_mm2s_reader: SRAM read-port model, queue-based scoreboard,
// directed vector table, hand sequences for reset/ignored start, and randomized transfers.
module tb_sram_mm2s_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_mm2s_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  sram_mm2s_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [16];
  logic       csb_r;
  logic [3:0] addr_r;

  // SRAM model: inputs registered on posedge, data presented after the following negedge.
  always @(posedge clk) begin
    csb_r  <= bus.sram_csb;
    addr_r <= bus.sram_addr;
  end
  always @(negedge clk) begin
    if (csb_r === 1'b0) bus.sram_dout <= mem[addr_r];
  end

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int cur_len = 0;
  int cur_base = 0;
  int issued = 0;
  int popped = 0;
  bit stall_q = 1'b0;
  logic [7:0] held_data;
  logic held_last;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard: reads, occupancy bound, stall stability and beat contents.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.sram_csb === 1'b0) begin
        chk("read_in_range", int'(issued < cur_len), 1);
        chk("sram_addr", int'(bus.sram_addr), (cur_base + issued) % 16);
        issued++;
      end
      chk("occupancy", int'((issued - popped) <= 4), 1);
      if (stall_q) begin
        chk("valid_held", int'(bus.m_tvalid), 1);
        chk("data_held", int'(bus.m_tdata), int'(held_data));
        chk("last_held", int'(bus.m_tlast), int'(held_last));
      end
      if (bus.m_tvalid && bus.m_tready) begin
        chk("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("tdata", int'(bus.m_tdata), int'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        chk("tlast", int'(bus.m_tlast), int'(popped == cur_len - 1));
        popped++;
      end
      stall_q   = bus.m_tvalid && !bus.m_tready;
      held_data = bus.m_tdata;
      held_last = bus.m_tlast;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic expect_xfer(input int base, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % 16]);
    cur_base = base;
    cur_len  = len;
    issued   = 0;
    popped   = 0;
  endtask

  task automatic run_xfer(input int base, input int len, input bit rnd,
                          input int exp_first, input int exp_done, input bit poke);
    int cyc;
    int first;
    expect_xfer(base, len);
    bus.base_addr = 4'(base);
    bus.length    = 5'(len);
    bus.start     = 1'b1;
    bus.m_tready  = rnd ? 1'($urandom % 2) : 1'b1;
    first = -1;
    @(posedge clk); #1;
    cyc = 1;
    bus.start = 1'b0;
    while (!bus.done && cyc < 300) begin
      if (bus.m_tvalid && first < 0) first = cyc;
      chk("busy", int'(bus.busy), 1);
      if (poke && cyc == 4) begin
        bus.start     = 1'b1;
        bus.base_addr = 4'(base + 3);
        bus.length    = 5'd7;
      end else begin
        bus.start = 1'b0;
      end
      bus.m_tready = rnd ? 1'($urandom % 2) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_seen", int'(bus.done), 1);
    if (exp_done != 0) chk("done_cycle", cyc, exp_done);
    if (exp_first != 0) chk("first_valid", first, exp_first);
    chk("busy_at_done", int'(bus.busy), 0);
    chk("all_beats", exp_q.size(), 0);
    chk("reads", issued, len);
    @(posedge clk); #1;
    chk("done_pulse", int'(bus.done), 0);
    chk("idle_valid", int'(bus.m_tvalid), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_csb"}, int'(bus.sram_csb), 1);
    chk({tag, "_addr"}, int'(bus.sram_addr), 0);
    chk({tag, "_tvalid"}, int'(bus.m_tvalid), 0);
    chk({tag, "_tlast"}, int'(bus.m_tlast), 0);
    chk({tag, "_tdata"}, int'(bus.m_tdata), 0);
  endtask

  typedef struct {
    int base;
    int len;
    bit rnd;
    int exp_first;
    int exp_done;
    bit poke;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int guard;
    vecs[0] = '{base: 2,  len: 4,  rnd: 1'b0, exp_first: 3, exp_done: 7,  poke: 1'b0};
    vecs[1] = '{base: 14, len: 4,  rnd: 1'b0, exp_first: 3, exp_done: 7,  poke: 1'b0};
    vecs[2] = '{base: 0,  len: 16, rnd: 1'b0, exp_first: 3, exp_done: 19, poke: 1'b0};
    vecs[3] = '{base: 0,  len: 16, rnd: 1'b1, exp_first: 0, exp_done: 0,  poke: 1'b0};
    vecs[4] = '{base: 7,  len: 0,  rnd: 1'b0, exp_first: 0, exp_done: 1,  poke: 1'b0};
    vecs[5] = '{base: 9,  len: 6,  rnd: 1'b0, exp_first: 3, exp_done: 9,  poke: 1'b1};
    vecs[6] = '{base: 11, len: 16, rnd: 1'b1, exp_first: 0, exp_done: 0,  poke: 1'b0};
    vecs[7] = '{base: 15, len: 1,  rnd: 1'b0, exp_first: 3, exp_done: 4,  poke: 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = 4'd0;
    bus.length    = 5'd0;
    bus.m_tready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].rnd,
               vecs[v].exp_first, vecs[v].exp_done, vecs[v].poke);
    end

    // Abort a len=8 transfer right after its third beat.
    expect_xfer(0, 8);
    bus.base_addr = 4'd0;
    bus.length    = 5'd8;
    bus.start     = 1'b1;
    bus.m_tready  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    guard = 0;
    while (popped < 3 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("third_beat_seen", popped, 3);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    cur_len = 0;
    issued  = 0;
    popped  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_abort_valid", int'(bus.m_tvalid), 0);
    run_xfer(5, 2, 1'b0, 3, 5, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_xfer(int'($urandom % 16), int'($urandom_range(0, 16)), 1'b1, 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
